neuron_mac_sequencer: RTL and testbench

- Single-neuron weight-fetch and multiply-accumulate stage; direct consumer of the weight ROM.
- On `start`, it walks N_INPUTS consecutive ROM addresses from a supplied base and drives the ROM address/enable.
- Each cycle it multiplies the returned signed 8-bit weight by the matching signed 8-bit activation, then adds a bias word stored at ROM address base+N_INPUTS.
- It presents the accumulated pre-activation with a valid/ready handshake to the next layer stage.

---
 rtl/neuron_mac_sequencer.sv | 178 +++++++++++++++++
 tb/tb_neuron_mac_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_sequencer.sv
// Single-neuron weight-fetch / multiply-accumulate stage: walks N_INPUTS ROM weights, adds a bias word, hands off the result.
// Define NEURON_RELU_EN to clamp negative pre-activations to zero in the bias step.

`default_nettype none

module neuron_mac_sequencer #(
    parameter int N_INPUTS  = 8,
    parameter int ACC_WIDTH = 20
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [7:0]                  base_addr,
    output logic                        busy,
    output logic [7:0]                  rom_address,
    output logic                        rom_enable,
    input  logic [7:0]                  rom_data,
    output logic [7:0]                  in_index,
    input  logic [7:0]                  in_data,
    output logic signed [ACC_WIDTH-1:0] result,
    output logic                        result_valid,
    input  logic                        result_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_BIAS,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(N_INPUTS - 1);
    localparam logic [7:0] BIAS_OFS = 8'(N_INPUTS);

    state_t r_state;
    state_t w_next_state;

    logic [7:0]                  r_base;
    logic [7:0]                  r_cnt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [7:0]                  r_rom_address;
    logic                        r_rom_enable;
    logic [7:0]                  r_in_index;
    logic signed [ACC_WIDTH-1:0] r_result;
    logic                        r_result_valid;

    logic                        w_last;
    logic                        w_load;
    logic                        w_accumulate;
    logic                        w_step;
    logic                        w_finish_fetch;
    logic                        w_bias;
    logic                        w_release;
    logic signed [15:0]          w_product;
    logic signed [ACC_WIDTH-1:0] w_product_ext;
    logic signed [ACC_WIDTH-1:0] w_bias_ext;
    logic signed [ACC_WIDTH-1:0] w_mac_sum;
    logic signed [ACC_WIDTH-1:0] w_bias_sum;
    logic signed [ACC_WIDTH-1:0] w_result_nxt;

    assign w_last = (r_cnt == LAST_IDX);

    // Both operands are 8-bit signed, so the full 16-bit product never overflows.
    assign w_product     = $signed(rom_data) * $signed(in_data);
    assign w_product_ext = {{(ACC_WIDTH-16){w_product[15]}}, w_product};
    assign w_bias_ext    = {{(ACC_WIDTH-8){rom_data[7]}}, rom_data};
    assign w_mac_sum     = r_acc + w_product_ext;
    assign w_bias_sum    = r_acc + w_bias_ext;

`ifdef NEURON_RELU_EN
    assign w_result_nxt = w_bias_sum[ACC_WIDTH-1] ? '0 : w_bias_sum;
`else
    assign w_result_nxt = w_bias_sum;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start)        w_next_state = S_FETCH;
            S_FETCH: if (w_last)       w_next_state = S_BIAS;
            S_BIAS:                    w_next_state = S_DONE;
            S_DONE:  if (result_ready) w_next_state = S_IDLE;
            default:                   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy           = 1'b1;
        w_load         = 1'b0;
        w_accumulate   = 1'b0;
        w_step         = 1'b0;
        w_finish_fetch = 1'b0;
        w_bias         = 1'b0;
        w_release      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy   = 1'b0;
                w_load = start;
            end
            S_FETCH: begin
                w_accumulate   = 1'b1;
                w_step         = !w_last;
                w_finish_fetch = w_last;
            end
            S_BIAS: begin
                w_bias = 1'b1;
            end
            S_DONE: begin
                w_release = result_ready;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // NOTE: the whole datapath is reset so an aborted neuron can never leak a partial sum or stale valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base         <= '0;
            r_cnt          <= '0;
            r_acc          <= '0;
            r_rom_address  <= '0;
            r_rom_enable   <= 1'b0;
            r_in_index     <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_base        <= base_addr;
                r_rom_address <= base_addr;
                r_rom_enable  <= 1'b1;
                r_in_index    <= '0;
                r_acc         <= '0;
                r_cnt         <= '0;
            end
            if (w_accumulate) begin
                r_acc <= w_mac_sum;
            end
            if (w_step) begin
                r_cnt         <= r_cnt + 8'd1;
                r_in_index    <= r_in_index + 8'd1;
                r_rom_address <= r_rom_address + 8'd1;
            end
            // Bias sits one past the last weight; 8-bit add wraps modulo 256.
            if (w_finish_fetch) begin
                r_rom_address <= r_base + BIAS_OFS;
            end
            if (w_bias) begin
                r_result       <= w_result_nxt;
                r_result_valid <= 1'b1;
                r_rom_enable   <= 1'b0;
            end
            if (w_release) begin
                r_result_valid <= 1'b0;
            end
        end
    end

    assign rom_address  = r_rom_address;
    assign rom_enable   = r_rom_enable;
    assign in_index     = r_in_index;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule

`default_nettype wire

// File: tb/tb_neuron_mac_sequencer.sv
// Self-checking bench for neuron_mac_sequencer: table of neuron vectors against a ROM/activation model,
// plus hand-written reset-abort, backpressure and start-during-handshake sequences.

module tb_neuron_mac_sequencer;

    localparam int N  = 8;
    localparam int AW = 20;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [7:0]           base_addr = 8'h00;
    logic                 result_ready = 1'b0;
    logic                 busy;
    logic [7:0]           rom_address;
    logic                 rom_enable;
    logic [7:0]           rom_data;
    logic [7:0]           in_index;
    logic [7:0]           in_data;
    logic signed [AW-1:0] result;
    logic                 result_valid;

    logic [7:0] rom_mem [256];
    logic [7:0] act_mem [256];

    int n_vectors = 0;
    int n_miss    = 0;
    int exp_q [$];

    typedef struct {
        string       name;
        logic [7:0]  base;
        logic [63:0] w;      // weight i in byte i
        logic [63:0] a;      // activation i in byte i
        logic [7:0]  bias;
        int          expected;
    } vec_t;

    vec_t tbl [7];

    neuron_mac_sequencer #(.N_INPUTS(N), .ACC_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .busy         (busy),
        .rom_address  (rom_address),
        .rom_enable   (rom_enable),
        .rom_data     (rom_data),
        .in_index     (in_index),
        .in_data      (in_data),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    assign rom_data = rom_enable ? rom_mem[rom_address] : 8'hxx;
    assign in_data  = act_mem[in_index];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int exp_of(input int v);
`ifdef NEURON_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic load_vec(input vec_t v);
        logic [7:0] adr;
        for (int i = 0; i < N; i++) begin
            adr          = v.base + 8'(i);
            rom_mem[adr] = v.w[8*i +: 8];
            act_mem[i]   = v.a[8*i +: 8];
        end
        adr          = v.base + 8'(N);
        rom_mem[adr] = v.bias;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"},   busy,         0);
        check({tag, " en"},     rom_enable,   0);
        check({tag, " valid"},  result_valid, 0);
    endtask

    // Called at a negedge; returns at the negedge right after the handshake edge.
    task automatic run_vec(input vec_t v, input int hold_cycles, input bit start_on_release);
        logic [7:0] ea;
        int         exp_res;
        load_vec(v);
        exp_res   = exp_of(v.expected);
        base_addr = v.base;
        start     = 1'b1;
        exp_q.push_back(exp_res);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= N; k++) begin
            ea = v.base + 8'(k);
            check($sformatf("%s addr[%0d]", v.name, k), rom_address, ea);
            check($sformatf("%s idx[%0d]", v.name, k),  in_index, (k < N) ? k : N - 1);
            check($sformatf("%s en[%0d]", v.name, k),   rom_enable, 1);
            check($sformatf("%s early_valid[%0d]", v.name, k), result_valid, 0);
            check($sformatf("%s busy[%0d]", v.name, k), busy, 1);
            @(negedge clk);
        end
        check({v.name, " valid"}, result_valid, 1);
        check({v.name, " en_off"}, rom_enable, 0);
        if (exp_q.size() == 0) begin
            check({v.name, " scoreboard_empty"}, 1, 0);
        end else begin
            check({v.name, " result"}, result, exp_q.pop_front());
        end
        for (int h = 0; h < hold_cycles; h++) begin
            start     = 1'b1;
            base_addr = 8'h55;
            @(negedge clk);
            check($sformatf("%s hold_valid[%0d]", v.name, h),  result_valid, 1);
            check($sformatf("%s hold_result[%0d]", v.name, h), result, exp_res);
            check($sformatf("%s hold_busy[%0d]", v.name, h),   busy, 1);
            check($sformatf("%s hold_en[%0d]", v.name, h),     rom_enable, 0);
        end
        start        = start_on_release;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        start        = 1'b0;
        check_idle({v.name, " release"});
        check({v.name, " result_kept"}, result, exp_res);
        if (start_on_release) begin
            @(negedge clk);
            check_idle({v.name, " start_not_queued"});
        end
    endtask

    initial begin
        tbl[0] = '{"basic",  8'h10, 64'h02_05_05_06_05_02_03_01, 64'h02_02_02_02_02_02_02_02, 8'h04, 62};
        tbl[1] = '{"signed", 8'h40, 64'h80_80_80_80_80_80_80_80, 64'h7f_7f_7f_7f_7f_7f_7f_7f, 8'hff, -130049};
        tbl[2] = '{"wrap",   8'hfc, 64'h08_07_06_05_04_03_02_01, 64'hff_ff_ff_ff_ff_ff_ff_ff, 8'h0a, -26};
        tbl[3] = '{"maxpos", 8'h60, 64'h80_80_80_80_80_80_80_80, 64'h80_80_80_80_80_80_80_80, 8'h7f, 131199};
        tbl[4] = '{"b2b20",  8'h20, 64'h7f_7f_7f_7f_7f_7f_7f_7f, 64'h81_81_81_81_81_81_81_81, 8'h80, -129160};
        tbl[5] = '{"zerow",  8'h80, 64'h00_00_00_00_00_00_00_00, 64'h55_55_55_55_55_55_55_55, 8'h05, 5};
        tbl[6] = '{"altsum", 8'ha0, 64'hf6_0a_f6_0a_f6_0a_f6_0a, 64'h03_03_03_03_03_03_03_03, 8'hf6, -10};

        for (int i = 0; i < 256; i++) begin
            rom_mem[i] = 8'(i * 7 + 3);
            act_mem[i] = 8'h00;
        end

        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset addr",   rom_address, 0);
        check("reset idx",    in_index,    0);
        check("reset result", result,      0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("idle_hold");

        // Backpressure: result held 5 cycles with start pulses ignored.
        run_vec(tbl[0], 5, 1'b0);

        // Table sweep; consecutive runs restart the cycle right after the handshake.
        for (int i = 0; i < 7; i++) begin
            run_vec(tbl[i], i % 3, (i == 2));
        end

        // Abort mid-FETCH with an asynchronous reset, then confirm nothing is ever presented.
        load_vec(tbl[1]);
        base_addr = tbl[1].base;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort pre_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle("abort async");
        check("abort addr",   rom_address, 0);
        check("abort idx",    in_index,    0);
        check("abort result", result,      0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < N + 3; c++) begin
            @(negedge clk);
            check($sformatf("abort no_valid[%0d]", c), result_valid, 0);
            check($sformatf("abort no_busy[%0d]", c),  busy, 0);
        end

        // Fresh neuron after reset must match a clean accumulation.
        run_vec(tbl[3], 1, 1'b0);

        check("scoreboard drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miss);
        $finish;
    end

endmodule
